// File: rtl/add8u_share_pkg.sv
// Shared types and widths for the round-robin approximate-adder share block.
package add8u_share_pkg;

    localparam int SUM_W = 9;
    localparam int OPW   = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/add8u_core.sv
// Combinational 8-bit approximate adder: the two low bits are OR'ed, and the upper
// six bits are added exactly, using a[1]&b[1] as their carry-in.
module add8u_core
    import add8u_share_pkg::*;
(
    input  logic [OPW-1:0]   A,
    input  logic [OPW-1:0]   B,
    output logic [SUM_W-1:0] O
);

    logic [6:0] upper;

    assign upper = {1'b0, A[7:2]} + {1'b0, B[7:2]} + {6'd0, A[1] & B[1]};
    assign O     = {upper, A[1:0] | B[1:0]};

endmodule

// File: rtl/add8u_rr_share.sv
// Round-robin share of one add8u_core among NREQ valid/ready requesters.
// It has a one-entry registered output. Define ADD8U_ERRMON_EN to add the error-monitor outputs.
//
// state | meaning
// EMPTY | no result held, out_valid=0
// FULL  | result held in out_sum/out_id, out_valid=1
module add8u_rr_share
    import add8u_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [OPW*NREQ-1:0] req_a,
    input  logic [OPW*NREQ-1:0] req_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SUM_W-1:0]    out_sum,
    output logic [IDW-1:0]      out_id,
    output logic [CNTW-1:0]     op_count
`ifdef ADD8U_ERRMON_EN
    ,
    output logic [SUM_W-1:0]    out_err,
    output logic [SUM_W-1:0]    err_max
`endif
);

    out_state_e        state_q, state_d;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    grant;
    logic              grant_found;
    logic              can_accept;
    logic              accept;
    logic [OPW-1:0]    sel_a, sel_b;
    logic [SUM_W-1:0]  core_o;

    // Scans from ptr upward, modulo NREQ. The loop runs in reverse so that the
    // smallest offset is the last one to write the result.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v,
                                             input logic [IDW-1:0]  ptr);
        int j;
        rr_pick = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (v[j]) rr_pick = {1'b1, IDW'(j)};
        end
    endfunction

    assign {grant_found, grant} = rr_pick(req_valid, rr_ptr);
    assign out_valid  = (state_q == FULL);
    assign can_accept = (state_q == EMPTY) || out_ready;

    always_comb begin
        req_ready = '0;
        if (!rst && can_accept && grant_found) req_ready[grant] = 1'b1;
    end

    assign accept = |(req_valid & req_ready);
    assign sel_a  = req_a[int'(grant)*OPW +: OPW];
    assign sel_b  = req_b[int'(grant)*OPW +: OPW];

    add8u_core u_core (
        .A (sel_a),
        .B (sel_b),
        .O (core_o)
    );

    always_comb begin
        state_d = state_q;
        if (accept)                            state_d = FULL;
        else if (state_q == FULL && out_ready) state_d = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            rr_ptr   <= '0;
            out_sum  <= '0;
            out_id   <= '0;
            op_count <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                out_sum <= core_o;
                out_id  <= grant;
                rr_ptr  <= (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
                if (op_count != '1) op_count <= op_count + CNTW'(1);
            end
        end
    end

`ifdef ADD8U_ERRMON_EN
    logic [SUM_W-1:0] exact_sum;
    logic [SUM_W-1:0] abs_err;

    assign exact_sum = {1'b0, sel_a} + {1'b0, sel_b};
    assign abs_err   = (core_o >= exact_sum) ? core_o - exact_sum : exact_sum - core_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_err <= '0;
            err_max <= '0;
        end else if (accept) begin
            out_err <= abs_err;
            if (abs_err > err_max) err_max <= abs_err;
        end
    end
`endif

endmodule

// File: tb/tb_add8u_rr_share.sv
// Directed bench for add8u_rr_share with NREQ=4 and CNTW=4, so that saturation is reachable.
// Error-monitor checks are compiled in when ADD8U_ERRMON_EN is defined.
module tb_add8u_rr_share;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a, req_b;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_sum;
    logic [1:0]  out_id;
    logic [3:0]  op_count;
`ifdef ADD8U_ERRMON_EN
    logic [8:0]  out_err, err_max;
`endif

    add8u_rr_share #(.NREQ(4), .IDW(2), .CNTW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_id    (out_id),
        .op_count  (op_count)
`ifdef ADD8U_ERRMON_EN
        ,
        .out_err   (out_err),
        .err_max   (err_max)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_sum = '0;
    int         exp_cnt = 0;
    int         exp_err = 0;
    int         exp_errmax = 0;

    typedef struct {
        logic [3:0] v;
        logic       ordy;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] rdy;
        logic       ov;
        int         id;
    } vec_t;
    vec_t tbl[$];

    function automatic int core_model(input int a, input int b);
        int hi;
        hi = (a >> 2) + (b >> 2) + (((a & b & 2) != 0) ? 1 : 0);
        return hi * 4 + ((a | b) & 3);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Lane i gets operand a+i and operand b. erdy/eov/eid give the expected handshake and output.
    task automatic cycle(input logic [3:0] v, input logic ordy, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] erdy, input logic eov,
                         input int eid);
        int g;
        int ea;
        req_valid = v;
        out_ready = ordy;
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = a + 8'(i);
            req_b[i*8 +: 8] = b;
        end
        #1;
        chk("req_ready", int'(req_ready), int'(erdy));
        if (erdy != 4'b0000) begin
            g = 0;
            for (int i = 0; i < 4; i++) if (erdy[i]) g = i;
            ea = int'(8'(a + 8'(g)));
            exp_sum = 9'(core_model(ea, int'(b)));
            if (exp_cnt < 15) exp_cnt++;
            exp_err = (int'(exp_sum) > ea + int'(b)) ? int'(exp_sum) - ea - int'(b)
                                                    : ea + int'(b) - int'(exp_sum);
            if (exp_err > exp_errmax) exp_errmax = exp_err;
        end
        @(posedge clk);
        #1;
        chk("out_valid", int'(out_valid), int'(eov));
        if (eov) begin
            chk("out_id", int'(out_id), eid);
            chk("out_sum", int'(out_sum), int'(exp_sum));
`ifdef ADD8U_ERRMON_EN
            chk("out_err", int'(out_err), exp_err);
`endif
        end
        chk("op_count", int'(op_count), exp_cnt);
`ifdef ADD8U_ERRMON_EN
        chk("err_max", int'(err_max), exp_errmax);
`endif
    endtask

    function automatic void add(input logic [3:0] v, input logic ordy, input logic [7:0] a,
                                input logic [7:0] b, input logic [3:0] rdy, input logic ov,
                                input int id);
        vec_t r;
        r.v = v; r.ordy = ordy; r.a = a; r.b = b; r.rdy = rdy; r.ov = ov; r.id = id;
        tbl.push_back(r);
    endfunction

    initial begin
        logic [7:0] fa[8];
        logic [7:0] fb[8];
        int prev_max;
        fa = '{8'h01, 8'h7F, 8'hA5, 8'hE3, 8'h0F, 8'hF0, 8'h55, 8'hAA};
        fb = '{8'h02, 8'h81, 8'h5A, 8'h1C, 8'hF1, 8'h0F, 8'hAA, 8'h55};

        // The table starts in FULL with rr_ptr=3, right after the single-op sequence.
        add(4'b0000, 1'b1, 8'h00, 8'h00, 4'b0000, 1'b0, 0);
        add(4'b1001, 1'b1, 8'h10, 8'h20, 4'b1000, 1'b1, 3);
        add(4'b1001, 1'b1, 8'hFF, 8'h01, 4'b0001, 1'b1, 0);
        add(4'b1001, 1'b1, 8'h3C, 8'h44, 4'b1000, 1'b1, 3);
        for (int k = 0; k < 8; k++)
            add(4'b1111, 1'b1, fa[k], fb[k], 4'(1 << (k % 4)), 1'b1, k % 4);
        for (int k = 0; k < 5; k++)
            add(4'b1111, 1'b0, 8'h00, 8'h00, 4'b0000, 1'b1, 3);
        add(4'b1111, 1'b1, 8'h11, 8'h22, 4'b0001, 1'b1, 0);
        for (int k = 1; k < 8; k++)
            add(4'b1111, 1'b1, fb[k], fa[k], 4'(1 << (k % 4)), 1'b1, k % 4);
        add(4'b0000, 1'b1, 8'h00, 8'h00, 4'b0000, 1'b0, 0);
        add(4'b0000, 1'b0, 8'h00, 8'h00, 4'b0000, 1'b0, 0);
        add(4'b0010, 1'b0, 8'h40, 8'h40, 4'b0010, 1'b1, 1);
        add(4'b0010, 1'b0, 8'h40, 8'h40, 4'b0000, 1'b1, 1);

        // Hold reset for two cycles with every requester valid.
        rst = 1'b1;
        req_valid = 4'b1111;
        out_ready = 1'b1;
        req_a = 32'h0403_0201;
        req_b = 32'h0807_0605;
        #1;
        chk("rst_req_ready", int'(req_ready), 0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("rst_req_ready", int'(req_ready), 0);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_op_count", int'(op_count), 0);
            chk("rst_out_sum", int'(out_sum), 0);
            chk("rst_out_id", int'(out_id), 0);
        end
        rst = 1'b0;

        // Single op on requester 2: 0x12 + 0x34 gives the core result 0x046.
        req_valid = 4'b0100;
        req_a = 32'h0012_0000;
        req_b = 32'h0034_0000;
        #1;
        chk("single_req_ready", int'(req_ready), 4);
        @(posedge clk);
        #1;
        chk("single_out_valid", int'(out_valid), 1);
        chk("single_out_id", int'(out_id), 2);
        chk("single_out_sum", int'(out_sum), 'h046);
        chk("single_op_count", int'(op_count), 1);
        exp_sum = 9'h046;
        exp_cnt = 1;

        foreach (tbl[n])
            cycle(tbl[n].v, tbl[n].ordy, tbl[n].a, tbl[n].b, tbl[n].rdy, tbl[n].ov, tbl[n].id);

        // Reset while FULL and backpressured discards the held result.
        rst = 1'b1;
        #1;
        chk("midrst_req_ready", int'(req_ready), 0);
        @(posedge clk);
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_op_count", int'(op_count), 0);
        chk("midrst_out_sum", int'(out_sum), 0);
        rst = 1'b0;
        exp_cnt = 0;
        exp_errmax = 0;

        // Random operand stream with all requesters valid: grants rotate 0,1,2,3.
        prev_max = 0;
        for (int k = 0; k < 200; k++) begin
            cycle(4'b1111, 1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  4'(1 << (k % 4)), 1'b1, k % 4);
`ifdef ADD8U_ERRMON_EN
            chk("err_max_monotonic", int'(err_max >= 9'(prev_max)), 1);
            prev_max = int'(err_max);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
